jtag_tap_ctrl: RTL and testbench
================================

Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller that fronts the SoC debug unit.
- Runs the 16-state TAP FSM, a 4-bit instruction register, and BYPASS/IDCODE/USERCODE data registers.
- Exports TAP state strobes plus a debug-select/TDI/TDO channel to the advanced debug interface, which owns its own DR chain.

Parameters:
- TECHNOLOGY, "Generic", technology selector; no functional effect in the generic implementation.
- JTAG_IDCODE, 32'h000009DD, value captured into the IDCODE DR; bit 0 must be 1.
- JTAG_USERCODE, 32'h00000000, value captured into the USERCODE DR.

Ports:
- jtag_tck  in  1  TAP clock; the single clock; both edges used.
- jtag_trst  in  1  asynchronous active-high reset (power-on OR test reset, combined externally).
- jtag_tms  in  1  test mode select, sampled on rising jtag_tck.
- jtag_tdi  in  1  test data in.
- jtag_tdo  out  1  test data out, changes on falling jtag_tck.
- jtag_tdo_oe  out  1  TDO output enable.
- tap_tck  out  1  buffered jtag_tck for the debug unit.
- tap_TestLogicReset  out  1  FSM in Test-Logic-Reset.
- tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR  out  1 each  FSM in the named DR state.
- dbg_sel  out  1  active instruction is DEBUG.
- dbg_tdi  out  1  TDI forwarded to the debug unit.
- dbg_tdo  in  1  serial data returned from the debug unit's DR chain.

Behaviour:
- Clocking and reset:
  - One clock (jtag_tck); reset is asynchronous and active-high.
  - While jtag_trst=1 or after its release: state=Test-Logic-Reset, IR=IDCODE (4'h2), jtag_tdo=0, jtag_tdo_oe=0, all DR shift registers cleared.
- FSM: standard 16 states, transitions on rising tck per TMS:
  - TLR: 1→TLR, 0→RTI
  - RTI: 0→RTI, 1→SelDR
  - SelDR: 0→CapDR, 1→SelIR
  - CapDR: 0→ShDR, 1→Ex1DR
  - ShDR: 0→ShDR, 1→Ex1DR
  - Ex1DR: 0→PauseDR, 1→UpdDR
  - PauseDR: 0→PauseDR, 1→Ex2DR
  - Ex2DR: 0→ShDR, 1→UpdDR
  - UpdDR: 0→RTI, 1→SelDR
  - SelIR: 0→CapIR, 1→TLR
  - IR branch mirrors the DR branch.
  - Five consecutive TMS=1 reach TLR from any state.
- Instruction register: 4 bits.
  - Capture-IR loads shift register with 4'b0101.
  - Shift-IR shifts LSB first, TDI into bit 3.
  - Update-IR latches the active IR on the rising edge in Update-IR.
  - Entering TLR forces IR=IDCODE.
- Opcodes:
  - EXTEST 0x0, SAMPLE_PRELOAD 0x1, IDCODE 0x2, USERCODE 0x7, DEBUG 0x8, MBIST 0x9, BYPASS 0xF.
  - Any undefined opcode behaves as BYPASS.
  - EXTEST, SAMPLE_PRELOAD and MBIST also select the bypass bit (no boundary scan implemented).
- Data registers:
  - Bypass: 1 bit; captures 0, shifts TDI.
  - IDCODE: 32 bits; captures JTAG_IDCODE in Capture-DR; shifts LSB first with TDI into bit 31.
  - USERCODE: 32 bits; same as IDCODE but captures JTAG_USERCODE.
  - DEBUG: no local register; the debug unit shifts on tap_ShiftDR.
- Output timing:
  - TDO mux: Shift-IR→IR shift bit 0; Shift-DR→selected DR bit 0 (dbg_tdo for DEBUG).
  - jtag_tdo and jtag_tdo_oe register the mux output and (ShiftIR|ShiftDR) on the falling tck edge; both hold 0 otherwise.
- Combinational outputs:
  - tap_* strobes decode the current state.
  - dbg_sel = (IR==DEBUG).
  - dbg_tdi = jtag_tdi.
  - tap_tck = jtag_tck.
- Pause/Exit states hold shift-register contents; shifting occurs only on rising edges while in Shift states.
- Reset asserted mid-shift aborts the operation: the IR returns to IDCODE and no Update occurs.

Test Plan:
- Reset, then TMS=0 once (RTI) → SelDR, CapDR, 32 ShDR cycles → TDO sequence, LSB first, equals 0x000009DD; jtag_tdo_oe=1 only during Shift-DR.
- Shift IR 4'h7 and Update-IR, then a 32-bit DR scan → USERCODE 0x00000000 shifted out.
- Shift IR 4'hF, then shift pattern 1,0,1,1 through DR → TDO equals the pattern delayed by one bit, first bit 0.
- Shift IR 4'h8 → dbg_sel=1; in Shift-DR, dbg_tdo toggling appears on jtag_tdo at the next falling edge; CaptureDR, ShiftDR, PauseDR and UpdateDR strobes each asserted exactly in their states.
- During Shift-IR the first four TDO bits read 1,0,1,0 (capture value 0101); IR opcode 0xC behaves as BYPASS.
- Hold TMS=1 for 5 cycles from Shift-DR → Test-Logic-Reset, tap_TestLogicReset=1, IR=IDCODE; assert jtag_trst mid-Shift-IR → immediate TLR, jtag_tdo_oe=0.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller fronting the SoC debug unit.
// Runs the 16-state TAP FSM, a 4-bit IR and the BYPASS/IDCODE/USERCODE DRs,
// and forwards a DEBUG select/TDI/TDO channel to the advanced debug interface.
// Ports:
//   jtag_tck/jtag_trst      TAP clock (both edges) / async active-high reset
//   jtag_tms/jtag_tdi       mode select and serial data in (sampled on rising tck)
//   jtag_tdo/jtag_tdo_oe    serial data out and its enable (updated on falling tck)
//   tap_tck, tap_*          buffered clock and TAP state strobes for the debug unit
//   dbg_sel/dbg_tdi/dbg_tdo DEBUG instruction select, forwarded TDI, returned data
module jtag_tap_ctrl #(
  parameter string       TECHNOLOGY    = "Generic",
  parameter logic [31:0] JTAG_IDCODE   = 32'h000009DD,
  parameter logic [31:0] JTAG_USERCODE = 32'h00000000
) (
  input  logic jtag_tck,
  input  logic jtag_trst,
  input  logic jtag_tms,
  input  logic jtag_tdi,
  output logic jtag_tdo,
  output logic jtag_tdo_oe,
  output logic tap_tck,
  output logic tap_TestLogicReset,
  output logic tap_CaptureDR,
  output logic tap_ShiftDR,
  output logic tap_PauseDR,
  output logic tap_UpdateDR,
  output logic dbg_sel,
  output logic dbg_tdi,
  input  logic dbg_tdo
);

  // Only the generic implementation exists; every technology maps onto it.
  if (TECHNOLOGY != "Generic") begin : g_tech_generic
  end

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI,
    ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAUSE_DR, ST_EX2_DR, ST_UPD_DR,
    ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAUSE_IR, ST_EX2_IR, ST_UPD_IR
  } tap_state_e;

  localparam logic [3:0] OP_IDCODE   = 4'h2;
  localparam logic [3:0] OP_USERCODE = 4'h7;
  localparam logic [3:0] OP_DEBUG    = 4'h8;

  tap_state_e  state_q, state_d;
  logic [3:0]  ir_q, ir_d;
  logic [3:0]  ir_sr_q, ir_sr_d;
  logic        bypass_q, bypass_d;
  logic [31:0] idcode_sr_q, idcode_sr_d;
  logic [31:0] usercode_sr_q, usercode_sr_d;
  logic        tdo_q, tdo_d;
  logic        tdo_oe_q, tdo_oe_d;
  logic        sel_idcode, sel_usercode, sel_debug;

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:      state_d = jtag_tms ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = jtag_tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = jtag_tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = jtag_tms ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    state_d = jtag_tms ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   state_d = jtag_tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = jtag_tms ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   state_d = jtag_tms ? ST_UPD_DR   : ST_SH_DR;
      ST_UPD_DR:   state_d = jtag_tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = jtag_tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = jtag_tms ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    state_d = jtag_tms ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   state_d = jtag_tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = jtag_tms ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   state_d = jtag_tms ? ST_UPD_IR   : ST_SH_IR;
      ST_UPD_IR:   state_d = jtag_tms ? ST_SEL_DR   : ST_RTI;
    endcase
  end

  // Undefined opcodes, EXTEST, SAMPLE_PRELOAD and MBIST all fall through to bypass.
  assign sel_idcode   = (ir_q == OP_IDCODE);
  assign sel_usercode = (ir_q == OP_USERCODE);
  assign sel_debug    = (ir_q == OP_DEBUG);

  // Instruction and data register paths
  always_comb begin
    ir_sr_d       = ir_sr_q;
    ir_d          = ir_q;
    bypass_d      = bypass_q;
    idcode_sr_d   = idcode_sr_q;
    usercode_sr_d = usercode_sr_q;

    if (state_q == ST_CAP_IR)     ir_sr_d = 4'b0101;
    else if (state_q == ST_SH_IR) ir_sr_d = {jtag_tdi, ir_sr_q[3:1]};

    if (state_q == ST_UPD_IR) ir_d = ir_sr_q;
    if (state_d == ST_TLR)    ir_d = OP_IDCODE;

    if (state_q == ST_CAP_DR) begin
      if (sel_idcode)        idcode_sr_d   = JTAG_IDCODE;
      else if (sel_usercode) usercode_sr_d = JTAG_USERCODE;
      else if (!sel_debug)   bypass_d      = 1'b0;
    end else if (state_q == ST_SH_DR) begin
      if (sel_idcode)        idcode_sr_d   = {jtag_tdi, idcode_sr_q[31:1]};
      else if (sel_usercode) usercode_sr_d = {jtag_tdi, usercode_sr_q[31:1]};
      else if (!sel_debug)   bypass_d      = jtag_tdi;
    end
  end

  // TDO mux, registered on the falling edge
  always_comb begin
    tdo_d    = 1'b0;
    tdo_oe_d = 1'b0;
    if (state_q == ST_SH_IR) begin
      tdo_d    = ir_sr_q[0];
      tdo_oe_d = 1'b1;
    end else if (state_q == ST_SH_DR) begin
      tdo_oe_d = 1'b1;
      if (sel_idcode)        tdo_d = idcode_sr_q[0];
      else if (sel_usercode) tdo_d = usercode_sr_q[0];
      else if (sel_debug)    tdo_d = dbg_tdo;
      else                   tdo_d = bypass_q;
    end
  end

  always_ff @(posedge jtag_tck or posedge jtag_trst) begin
    if (jtag_trst) begin
      state_q       <= ST_TLR;
      ir_q          <= OP_IDCODE;
      ir_sr_q       <= '0;
      bypass_q      <= 1'b0;
      idcode_sr_q   <= '0;
      usercode_sr_q <= '0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_sr_q       <= ir_sr_d;
      bypass_q      <= bypass_d;
      idcode_sr_q   <= idcode_sr_d;
      usercode_sr_q <= usercode_sr_d;
    end
  end

  always_ff @(negedge jtag_tck or posedge jtag_trst) begin
    if (jtag_trst) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign jtag_tdo           = tdo_q;
  assign jtag_tdo_oe        = tdo_oe_q;
  assign tap_tck            = jtag_tck;
  assign tap_TestLogicReset = (state_q == ST_TLR);
  assign tap_CaptureDR      = (state_q == ST_CAP_DR);
  assign tap_ShiftDR        = (state_q == ST_SH_DR);
  assign tap_PauseDR        = (state_q == ST_PAUSE_DR);
  assign tap_UpdateDR       = (state_q == ST_UPD_DR);
  assign dbg_sel            = sel_debug;
  assign dbg_tdi            = jtag_tdi;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: table of IR/DR scans, a table-driven
// DR-branch walk for the state strobes, and hand-written reset sequences.
module tb_jtag_tap_ctrl;

  logic jtag_tck, jtag_trst, jtag_tms, jtag_tdi, dbg_tdo;
  logic jtag_tdo, jtag_tdo_oe, tap_tck;
  logic tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR;
  logic dbg_sel, dbg_tdi;

  jtag_tap_ctrl #(
    .TECHNOLOGY   ("Generic"),
    .JTAG_IDCODE  (32'h000009DD),
    .JTAG_USERCODE(32'h00000000)
  ) dut (
    .jtag_tck          (jtag_tck),
    .jtag_trst         (jtag_trst),
    .jtag_tms          (jtag_tms),
    .jtag_tdi          (jtag_tdi),
    .jtag_tdo          (jtag_tdo),
    .jtag_tdo_oe       (jtag_tdo_oe),
    .tap_tck           (tap_tck),
    .tap_TestLogicReset(tap_TestLogicReset),
    .tap_CaptureDR     (tap_CaptureDR),
    .tap_ShiftDR       (tap_ShiftDR),
    .tap_PauseDR       (tap_PauseDR),
    .tap_UpdateDR      (tap_UpdateDR),
    .dbg_sel           (dbg_sel),
    .dbg_tdi           (dbg_tdi),
    .dbg_tdo           (dbg_tdo)
  );

  initial jtag_tck = 1'b0;
  always #10 jtag_tck = ~jtag_tck;

  localparam logic [31:0] IDCODE_VAL = 32'h000009DD;
  localparam int K_CAP = 0;
  localparam int K_BYP = 1;
  localparam int K_DBG = 2;

  typedef struct { logic tdo; logic oe; } exp_t;
  typedef struct { logic [3:0] op; int kind; logic [31:0] cap; logic [31:0] pat; logic sel; } ir_vec_t;
  typedef struct { logic tms; logic [4:0] strb; logic oe; } walk_t;

  exp_t    sb[$];
  ir_vec_t ir_tab[8];
  walk_t   walk_tab[11];
  int      n_checks = 0;
  int      n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One TCK cycle starting from just after a falling edge; the expectation is
  // queued on drive and compared once the next falling edge has updated TDO.
  task automatic step(input logic tms, input logic tdi, input logic e_tdo, input logic e_oe);
    exp_t e;
    e.tdo = e_tdo;
    e.oe  = e_oe;
    sb.push_back(e);
    jtag_tms = tms;
    jtag_tdi = tdi;
    @(negedge jtag_tck);
    #1;
    check("dbg_tdi", {31'b0, dbg_tdi}, {31'b0, tdi});
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("tdo", {31'b0, jtag_tdo}, {31'b0, e.tdo});
      check("tdo_oe", {31'b0, jtag_tdo_oe}, {31'b0, e.oe});
    end
  endtask

  // From Run-Test/Idle: load an opcode, checking the 0101 capture on TDO.
  task automatic load_ir(input logic [3:0] op);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, op[0], 1'b0, 1'b1);
    step(1'b0, op[1], 1'b1, 1'b1);
    step(1'b0, op[2], 1'b0, 1'b1);
    step(1'b1, op[3], 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // From Run-Test/Idle: 32-bit DR scan back to Run-Test/Idle.
  task automatic dr_scan(input int kind, input logic [31:0] cap, input logic [31:0] pat);
    logic [31:0] rx;
    rx = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j <= 32; j++) begin
      logic t, d, et, eo;
      t = (j == 0) ? 1'b0 : pat[j-1];
      d = 1'($urandom_range(0, 1));
      dbg_tdo = d;
      if (j == 32) begin
        et = 1'b0;
        eo = 1'b0;
      end else begin
        eo = 1'b1;
        if (kind == K_CAP)      et = cap[j];
        else if (kind == K_BYP) et = t;
        else                    et = d;
      end
      step(j == 32, t, et, eo);
      if (j < 32) rx[j] = jtag_tdo;
    end
    dbg_tdo = 1'b0;
    if (kind == K_CAP) check("dr_word", rx, cap);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ir_tab[0] = '{op: 4'h7, kind: K_CAP, cap: 32'h00000000, pat: $urandom(), sel: 1'b0};
    ir_tab[1] = '{op: 4'hF, kind: K_BYP, cap: 32'h0,        pat: 32'h0000000D, sel: 1'b0};
    ir_tab[2] = '{op: 4'h2, kind: K_CAP, cap: IDCODE_VAL,   pat: $urandom(), sel: 1'b0};
    ir_tab[3] = '{op: 4'h8, kind: K_DBG, cap: 32'h0,        pat: $urandom(), sel: 1'b1};
    ir_tab[4] = '{op: 4'hC, kind: K_BYP, cap: 32'h0,        pat: $urandom(), sel: 1'b0};
    ir_tab[5] = '{op: 4'h0, kind: K_BYP, cap: 32'h0,        pat: $urandom(), sel: 1'b0};
    ir_tab[6] = '{op: 4'h1, kind: K_BYP, cap: 32'h0,        pat: $urandom(), sel: 1'b0};
    ir_tab[7] = '{op: 4'h9, kind: K_BYP, cap: 32'h0,        pat: $urandom(), sel: 1'b0};

    // strobes order: {TestLogicReset, CaptureDR, ShiftDR, PauseDR, UpdateDR}
    walk_tab[0]  = '{tms: 1'b1, strb: 5'b00000, oe: 1'b0};  // Select-DR
    walk_tab[1]  = '{tms: 1'b0, strb: 5'b01000, oe: 1'b0};  // Capture-DR
    walk_tab[2]  = '{tms: 1'b0, strb: 5'b00100, oe: 1'b1};  // Shift-DR
    walk_tab[3]  = '{tms: 1'b1, strb: 5'b00000, oe: 1'b0};  // Exit1-DR
    walk_tab[4]  = '{tms: 1'b0, strb: 5'b00010, oe: 1'b0};  // Pause-DR
    walk_tab[5]  = '{tms: 1'b0, strb: 5'b00010, oe: 1'b0};  // Pause-DR
    walk_tab[6]  = '{tms: 1'b1, strb: 5'b00000, oe: 1'b0};  // Exit2-DR
    walk_tab[7]  = '{tms: 1'b0, strb: 5'b00100, oe: 1'b1};  // Shift-DR
    walk_tab[8]  = '{tms: 1'b1, strb: 5'b00000, oe: 1'b0};  // Exit1-DR
    walk_tab[9]  = '{tms: 1'b1, strb: 5'b00001, oe: 1'b0};  // Update-DR
    walk_tab[10] = '{tms: 1'b0, strb: 5'b00000, oe: 1'b0};  // Run-Test/Idle

    jtag_trst = 1'b1;
    jtag_tms  = 1'b1;
    jtag_tdi  = 1'b0;
    dbg_tdo   = 1'b0;
    repeat (3) @(negedge jtag_tck);
    #1;
    check("reset_tlr", {31'b0, tap_TestLogicReset}, 32'd1);
    check("reset_tdo", {31'b0, jtag_tdo}, 32'd0);
    check("reset_oe", {31'b0, jtag_tdo_oe}, 32'd0);
    check("reset_dbg_sel", {31'b0, dbg_sel}, 32'd0);
    jtag_trst = 1'b0;
    @(posedge jtag_tck);
    #2;
    check("tap_tck_high", {31'b0, tap_tck}, 32'd1);
    @(negedge jtag_tck);
    #1;
    check("tap_tck_low", {31'b0, tap_tck}, 32'd0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("tlr_hold", {31'b0, tap_TestLogicReset}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rti_entered", {31'b0, tap_TestLogicReset}, 32'd0);

    // Default IR after reset is IDCODE.
    dr_scan(K_CAP, IDCODE_VAL, $urandom());

    foreach (ir_tab[i]) begin
      load_ir(ir_tab[i].op);
      check($sformatf("dbg_sel_op%0h", ir_tab[i].op), {31'b0, dbg_sel}, {31'b0, ir_tab[i].sel});
      dr_scan(ir_tab[i].kind, ir_tab[i].cap, ir_tab[i].pat);
    end

    // DR branch walk with DEBUG selected and dbg_tdo held low.
    load_ir(4'h8);
    dbg_tdo = 1'b0;
    foreach (walk_tab[i]) begin
      step(walk_tab[i].tms, 1'b0, 1'b0, walk_tab[i].oe);
      check($sformatf("strobes_%0d", i),
            {27'b0, tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR},
            {27'b0, walk_tab[i].strb});
    end

    // Five TMS=1 from Shift-DR reach Test-Logic-Reset and restore IDCODE.
    load_ir(4'h7);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("tms5_tlr_%0d", i), {31'b0, tap_TestLogicReset}, (i == 4) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    dr_scan(K_CAP, IDCODE_VAL, $urandom());

    // Reset in the middle of Shift-IR aborts the load.
    load_ir(4'h8);
    check("dbg_sel_before_trst", {31'b0, dbg_sel}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    jtag_trst = 1'b1;
    #1;
    check("trst_tlr", {31'b0, tap_TestLogicReset}, 32'd1);
    check("trst_oe", {31'b0, jtag_tdo_oe}, 32'd0);
    check("trst_tdo", {31'b0, jtag_tdo}, 32'd0);
    check("trst_dbg_sel", {31'b0, dbg_sel}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("trst_held_tlr", {31'b0, tap_TestLogicReset}, 32'd1);
    jtag_trst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    dr_scan(K_CAP, IDCODE_VAL, $urandom());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
